audio_pwm_dac: RTL and testbench

//  Output stage of the audio path. Sits directly downstream of the tone/note sequencer.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_sample_fifo.sv | 53 +++++
 rtl/audio_pwm_dac.sv | 121 ++++++++++++
 tb/tb_audio_pwm_dac.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, sample type and PWM frame constants
// for the audio output path.
package audio_pkg;

  localparam int SAMPLE_W_DEF = 8;

  typedef logic [SAMPLE_W_DEF-1:0] sample_t;

  localparam sample_t MIDSCALE =
    sample_t'(1 << (SAMPLE_W_DEF - 1));

  localparam int PWM_FRAME_CLKS = 1 << SAMPLE_W_DEF;

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: synchronous sample FIFO, first-word fall-through,
// pointers carry an extra wrap bit so full and empty are distinct.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter  int W     = SAMPLE_W_DEF,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         wr_en, rd_en;

  assign level = wr_q - rd_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_q == rd_q);
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_en = push && !full;
    rd_en = pop && !empty;
    wr_d  = wr_q + (AW+1)'(wr_en);
    rd_d  = rd_q + (AW+1)'(rd_en);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/audio_pwm_dac.sv
// audio_pwm_dac: buffered PCM samples played as a PWM carrier.
// Define AUD_IDLE_SD_EN to shut the amplifier down after long underruns.
module audio_pwm_dac
  import audio_pkg::*;
#(
  parameter  int SAMPLE_W     = SAMPLE_W_DEF,
  parameter  int REPEAT       = 8,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int IDLE_TIMEOUT = 4096,
  localparam int LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_100m,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [LW-1:0]       fifo_level,
  output logic                underrun,
  output logic                AUD_PWM,
  output logic                AUD_SD
);

  localparam int FW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [SAMPLE_W-1:0] MID =
    {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [FW-1:0] LAST_FRAME = FW'(REPEAT - 1);

  logic [SAMPLE_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SAMPLE_W-1:0] cur_q, cur_d;
  logic [SAMPLE_W-1:0] duty, head;
  logic [FW-1:0]       frame_q, frame_d;
  logic                run_q;
  logic                pwm_q, pwm_d;
  logic                sd_q, sd_d;
  logic                push, pop, full, empty, slot;

  audio_sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_100m),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .dout  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // run_q keeps s_ready low while rst is held, high from the first edge after
  assign s_ready  = run_q && !full;
  assign push     = s_valid && s_ready;
  assign slot     = enable && (pwm_cnt_q == '0) && (frame_q == '0);
  assign pop      = slot && !empty;
  assign underrun = slot && empty && !rst;
  assign AUD_PWM  = pwm_q;
  assign AUD_SD   = sd_q;

  always_comb begin
    pwm_cnt_d = '0;
    frame_d   = '0;
    if (enable) begin
      pwm_cnt_d = pwm_cnt_q + SAMPLE_W'(1);
      frame_d   = frame_q;
      if (&pwm_cnt_q)
        frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + FW'(1);
    end
    duty = cur_q;
    if (slot) duty = empty ? MID : head;
    cur_d = duty;
    pwm_d = enable && (pwm_cnt_q < duty);
  end

`ifdef AUD_IDLE_SD_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

  logic [IW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (!enable || pop)
      idle_d = '0;
    else if (underrun && idle_q != IDLE_MAX)
      idle_d = idle_q + IW'(1);
    sd_d = enable && (idle_d != IDLE_MAX);
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_idle;
  assign unused_idle = (IDLE_TIMEOUT > 0);

  always_comb sd_d = enable;
`endif

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      frame_q   <= '0;
      cur_q     <= MID;
      run_q     <= 1'b0;
      pwm_q     <= 1'b0;
      sd_q      <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      frame_q   <= frame_d;
      cur_q     <= cur_d;
      run_q     <= 1'b1;
      pwm_q     <= pwm_d;
      sd_q      <= sd_d;
    end
  end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// tb_audio_pwm_dac: directed and random checks of audio_pwm_dac against
// a sample-slot level reference model.
module tb_audio_pwm_dac;

  localparam int RPT   = 8;
  localparam int DEPTH = 4;
  localparam int IDLE  = 4;
  localparam int SLOT  = 256 * RPT;

  logic       clk_100m = 1'b0;
  logic       rst      = 1'b1;
  logic       enable   = 1'b1;
  logic [7:0] s_data   = 8'hA5;
  logic       s_valid  = 1'b1;
  logic       s_ready;
  logic [2:0] fifo_level;
  logic       underrun;
  logic       AUD_PWM;
  logic       AUD_SD;

  int vec = 0;
  int bad = 0;

  audio_pwm_dac #(
    .SAMPLE_W     (8),
    .REPEAT       (RPT),
    .FIFO_DEPTH   (DEPTH),
    .IDLE_TIMEOUT (IDLE)
  ) dut (
    .clk_100m   (clk_100m),
    .rst        (rst),
    .enable     (enable),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .AUD_PWM    (AUD_PWM),
    .AUD_SD     (AUD_SD)
  );

  always #5 clk_100m = ~clk_100m;

  // Reference: time since enable, a sample queue and the playing sample.
  int m_q[$];
  int m_ph   = 0;
  int m_cur  = 128;
  int m_duty = 128;
  int m_idle = 0;
  bit m_pwm  = 0;
  bit m_sd   = 0;
  bit m_run  = 0;
  bit m_rdy, m_slot;

  always @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ph = 0; m_cur = 128; m_idle = 0;
      m_pwm = 0; m_sd = 0; m_run = 0;
    end else begin
      m_slot = enable && (m_ph == 0);
      m_rdy  = m_run && (m_q.size() < DEPTH);
      m_duty = m_cur;
      if (m_slot) begin
        if (m_q.size() > 0) begin
          m_duty = m_q.pop_front();
          m_idle = 0;
        end else begin
          m_duty = 128;
          if (m_idle < IDLE) m_idle++;
        end
        m_cur = m_duty;
      end
      if (!enable) m_idle = 0;
      if (s_valid && m_rdy) m_q.push_back(int'(s_data));
      m_pwm = enable && ((m_ph % 256) < m_duty);
`ifdef AUD_IDLE_SD_EN
      m_sd = enable && (m_idle < IDLE);
`else
      m_sd = enable;
`endif
      m_ph  = enable ? (m_ph + 1) % SLOT : 0;
      m_run = 1;
    end
  end

  function automatic bit exp_rdy();
    return m_run && (m_q.size() < DEPTH);
  endfunction

  function automatic bit exp_ur();
    return enable && !rst && (m_ph == 0) && (m_q.size() == 0);
  endfunction

  task automatic push_sample(input logic [7:0] d);
    bit got = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_100m);
      if (s_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk_100m); #1;
    s_valid = 1'b0;
    vec++;
    if (!got) begin
      bad++;
      $display("FAIL push_wait: s_ready=%b required 1 within 5000 cycles",
               s_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_100m);
    @(negedge clk_100m);
    vec += 5;
    if (AUD_PWM !== 1'b0) begin
      bad++; $display("FAIL rst_pwm: got %b want 0", AUD_PWM);
    end
    if (AUD_SD !== 1'b0) begin
      bad++; $display("FAIL rst_sd: got %b want 0", AUD_SD);
    end
    if (s_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready: got %b want 0", s_ready);
    end
    if (underrun !== 1'b0) begin
      bad++; $display("FAIL rst_underrun: got %b want 0", underrun);
    end
    if (fifo_level !== 3'd0) begin
      bad++; $display("FAIL rst_level: got %0d want 0", fifo_level);
    end
    enable  = 1'b0;
    s_valid = 1'b0;
    rst     = 1'b0;
    @(posedge clk_100m); #1;
    vec += 2;
    if (s_ready !== 1'b1) begin
      bad++; $display("FAIL rel_ready: got %b want 1", s_ready);
    end
    if (fifo_level !== 3'd0) begin
      bad++; $display("FAIL rel_level: got %0d want 0", fifo_level);
    end
  endtask

  task automatic test_duty(input logic [7:0] a, input logic [7:0] b);
    int hi;
    push_sample(a);
    push_sample(b);
    enable = 1'b1;
    for (int f = 0; f < 2 * RPT; f++) begin
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        @(negedge clk_100m);
        hi += int'(AUD_PWM);
        vec++;
        if (AUD_PWM !== m_pwm || AUD_SD !== m_sd ||
            s_ready !== exp_rdy() || underrun !== exp_ur() ||
            fifo_level !== 3'(m_q.size())) begin
          bad++;
          if (bad < 20)
            $display("FAIL duty_cyc f%0d c%0d: pwm=%b/%b sd=%b/%b rdy=%b lvl=%0d ur=%b",
                     f, c, AUD_PWM, m_pwm, AUD_SD, m_sd, s_ready,
                     fifo_level, underrun);
        end
      end
      vec++;
      if (hi !== ((f < RPT) ? int'(a) : int'(b))) begin
        bad++;
        $display("FAIL duty_frame %0d: high %0d want %0d", f, hi,
                 (f < RPT) ? int'(a) : int'(b));
      end
    end
    enable = 1'b0;
    @(posedge clk_100m); #1;
    vec++;
    if (AUD_PWM !== 1'b0) begin
      bad++; $display("FAIL duty_off: pwm %b want 0", AUD_PWM);
    end
  endtask

  task automatic test_fifo_full();
    for (int k = 0; k < DEPTH; k++) push_sample(8'($urandom));
    @(negedge clk_100m);
    vec += 2;
    if (fifo_level !== 3'd4) begin
      bad++; $display("FAIL full_level: got %0d want 4", fifo_level);
    end
    if (s_ready !== 1'b0) begin
      bad++; $display("FAIL full_ready: got %b want 0", s_ready);
    end
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_100m);
      vec++;
      if (s_ready !== 1'b0 || fifo_level !== 3'd4) begin
        bad++;
        $display("FAIL full_hold %0d: rdy=%b lvl=%0d want 0/4", i,
                 s_ready, fifo_level);
      end
    end
    enable = 1'b1;
    @(negedge clk_100m);
    vec++;
    if (fifo_level !== 3'd3 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL full_pop: lvl=%0d rdy=%b want 3/1", fifo_level, s_ready);
    end
    @(posedge clk_100m); #1;
    s_valid = 1'b0;
    @(negedge clk_100m);
    vec++;
    if (fifo_level !== 3'd4) begin
      bad++; $display("FAIL full_fifth: lvl=%0d want 4", fifo_level);
    end
    for (int i = 0; i < 5 * SLOT; i++) begin
      @(negedge clk_100m);
      vec++;
      if (AUD_PWM !== m_pwm || AUD_SD !== m_sd ||
          s_ready !== exp_rdy() || underrun !== exp_ur() ||
          fifo_level !== 3'(m_q.size())) begin
        bad++;
        if (bad < 20)
          $display("FAIL full_play %0d: pwm=%b/%b lvl=%0d/%0d ur=%b",
                   i, AUD_PWM, m_pwm, fifo_level, m_q.size(), underrun);
      end
    end
    vec++;
    if (fifo_level !== 3'd0) begin
      bad++; $display("FAIL full_drain: lvl=%0d want 0", fifo_level);
    end
    enable = 1'b0;
    @(posedge clk_100m); #1;
  endtask

  task automatic test_underrun();
    int ur = 0;
    int hi = 0;
    int sd_bad = 0;
    @(negedge clk_100m);
    enable = 1'b1;
    for (int i = 0; i < 3 * SLOT; i++) begin
      @(negedge clk_100m);
      ur += int'(underrun);
      hi += int'(AUD_PWM);
      if (AUD_SD !== 1'b1) sd_bad++;
    end
    vec += 3;
    if (ur !== 3) begin
      bad++; $display("FAIL ur_pulses: got %0d want 3", ur);
    end
    if (hi !== 3 * RPT * 128) begin
      bad++; $display("FAIL ur_duty: high %0d want %0d", hi, 3 * RPT * 128);
    end
    if (sd_bad !== 0) begin
      bad++; $display("FAIL ur_sd: %0d cycles low want 0", sd_bad);
    end
    enable = 1'b0;
    @(posedge clk_100m); #1;
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk_100m); #1;
      if (i == 12000) rst = 1'b1;
      if (i == 12003) rst = 1'b0;
      s_valid = (i < 8000) ? ($urandom % 400 == 0) : 1'($urandom);
      s_data  = 8'($urandom);
      if ($urandom % 3000 == 0) enable = !enable;
      @(negedge clk_100m);
      vec++;
      if (AUD_PWM !== m_pwm || AUD_SD !== m_sd ||
          s_ready !== exp_rdy() || underrun !== exp_ur() ||
          fifo_level !== 3'(m_q.size())) begin
        bad++;
        if (bad < 20)
          $display("FAIL rand %0d: pwm=%b/%b sd=%b/%b rdy=%b/%b lvl=%0d/%0d ur=%b/%b",
                   i, AUD_PWM, m_pwm, AUD_SD, m_sd, s_ready, exp_rdy(),
                   fifo_level, m_q.size(), underrun, exp_ur());
      end
    end
    s_valid = 1'b0;
    enable  = 1'b0;
    @(posedge clk_100m); #1;
  endtask

`ifdef AUD_IDLE_SD_EN
  task automatic test_idle();
    rst = 1'b1;
    @(posedge clk_100m); #1;
    rst    = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < IDLE * SLOT + 4; i++) begin
      @(negedge clk_100m);
      vec++;
      if (AUD_SD !== m_sd || AUD_PWM !== m_pwm) begin
        bad++;
        if (bad < 20)
          $display("FAIL idle_run %0d: sd=%b/%b pwm=%b/%b", i, AUD_SD,
                   m_sd, AUD_PWM, m_pwm);
      end
    end
    vec++;
    if (AUD_SD !== 1'b0) begin
      bad++; $display("FAIL idle_off: sd=%b want 0", AUD_SD);
    end
    push_sample(8'h10);
    for (int i = 0; i < 2 * SLOT; i++) begin
      @(negedge clk_100m);
      vec++;
      if (AUD_SD !== m_sd || AUD_PWM !== m_pwm) begin
        bad++;
        if (bad < 20)
          $display("FAIL idle_wake %0d: sd=%b/%b pwm=%b/%b", i, AUD_SD,
                   m_sd, AUD_PWM, m_pwm);
      end
    end
    enable = 1'b0;
    @(posedge clk_100m); #1;
  endtask
`endif

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_duty(8'h40, 8'hC0);
    test_duty(8'h00, 8'hFF);
    test_fifo_full();
    test_underrun();
    test_random();
`ifdef AUD_IDLE_SD_EN
    test_idle();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
